// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared types and constants for the hex keypad entry block.
//   - state_t     : scan FSM states (SCAN, DEBOUNCE, HELD)
//   - KEY_MAP     : 4x4 key map, nibble index {row,col}
//   - key_lookup  : returns the hex code of the key at (row_idx, col_idx)
//   - KEY_CLR/KEY_BS : edit keys, used when KEYPAD_EDIT_EN is defined
// ---------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] KEY_CLR = 4'hC;
   localparam logic [3:0] KEY_BS  = 4'hE;

   // Nibble {row,col} holds the code printed on that key.
   //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
   localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

   function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                             input logic [1:0] col_idx);
      logic [5:0] base;
      base = {row_idx, col_idx, 2'b00};
      return KEY_MAP[base +: 4];
   endfunction

endpackage

// File: rtl/row_sync.sv
// ---------------------------------------------------------------------------
// row_sync
//   Two-flop synchronizer for the asynchronous, active-low keypad rows.
//   Both stages reset to "no key" (all high).
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   row    in  4  raw keypad rows
//   row_s  out 4  synchronized rows
// ---------------------------------------------------------------------------
module row_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] row_s
);

   logic [3:0] row_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_p0 <= 4'b1111;
         row_s  <= 4'b1111;
      end else begin
         row_p0 <= row;
         row_s  <= row_p0;
      end
   end

endmodule

// File: rtl/hex_keypad_entry.sv
// ---------------------------------------------------------------------------
// hex_keypad_entry
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases,
//   and shifts accepted hex digits into a 32-bit value (newest in [3:0]).
// Parameters:
//   SCAN_DIV_W     column dwell = 2**SCAN_DIV_W clk cycles
//   DEBOUNCE_SCANS consecutive matching samples to accept a press/release
//   NUM_DIGITS     saturation point of digit_count
// Ports:
//   clk          in  1   system clock
//   rst_n        in  1   asynchronous active-low reset
//   row          in  4   keypad rows, active-low, asynchronous
//   col          out 4   column drive, active-low, one bit low
//   clear        in  1   synchronous clear of value and digit_count
//   value        out 32  entered number
//   digit_count  out 4   digits entered, 0..NUM_DIGITS
//   key_valid    out 1   one-cycle pulse per accepted key
//   key_code     out 4   code of the last accepted key
// Configuration:
//   KEYPAD_EDIT_EN  when defined, key C clears and key E is backspace.
// ---------------------------------------------------------------------------
module hex_keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_W     = 17,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int NUM_DIGITS     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        clear,
   output logic [31:0] value,
   output logic [3:0]  digit_count,
   output logic        key_valid,
   output logic [3:0]  key_code
);

   localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);

   logic [3:0]            row_s;
   logic [SCAN_DIV_W-1:0] dwell_cnt;
   logic                  sample;
   state_t                state;
   logic [1:0]            col_idx;
   logic [1:0]            key_row;
   logic [DB_W-1:0]       match_cnt;
   logic [DB_W-1:0]       rel_cnt;
   logic [DB_W-1:0]       match_nxt;
   logic [DB_W-1:0]       rel_nxt;
   logic                  any_low;
   logic [1:0]            low_idx;
   logic                  accept;
   logic [3:0]            accept_code;

   row_sync u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .row   (row),
      .row_s (row_s)
   );

   // Rows are only looked at on the last dwell cycle so the column drive
   // and the synchronizer have had the whole dwell to settle.
   assign sample    = &dwell_cnt;
   assign any_low   = ~&row_s;
   assign match_nxt = match_cnt + DB_W'(1);
   assign rel_nxt   = rel_cnt + DB_W'(1);

   // Lowest low row wins when several keys in the column are down.
   always_comb begin
      low_idx = 2'd0;
      if      (!row_s[0]) low_idx = 2'd0;
      else if (!row_s[1]) low_idx = 2'd1;
      else if (!row_s[2]) low_idx = 2'd2;
      else if (!row_s[3]) low_idx = 2'd3;
   end

   always_comb begin
      accept = 1'b0;
      if (sample && any_low) begin
         if (state == SCAN && DEBOUNCE_SCANS <= 1)
            accept = 1'b1;
         else if (state == DEBOUNCE && low_idx == key_row &&
                  match_nxt == DB_W'(DEBOUNCE_SCANS))
            accept = 1'b1;
      end
   end

   // On accept the column is still the latched one, and the matching row
   // is the current lowest low row.
   assign accept_code = key_lookup(low_idx, col_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_cnt <= '0;
         state     <= SCAN;
         col_idx   <= 2'd0;
         col       <= 4'b1110;
         key_row   <= 2'd0;
         match_cnt <= '0;
         rel_cnt   <= '0;
      end else begin
         dwell_cnt <= dwell_cnt + 1'b1;
         if (sample) begin
            case (state)
               SCAN: begin
                  if (!any_low) begin
                     col_idx <= col_idx + 2'd1;
                     col     <= {col[2:0], col[3]};
                  end else begin
                     key_row   <= low_idx;
                     match_cnt <= DB_W'(1);
                     rel_cnt   <= '0;
                     state     <= (DEBOUNCE_SCANS <= 1) ? HELD : DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (any_low && low_idx == key_row) begin
                     match_cnt <= match_nxt;
                     if (match_nxt == DB_W'(DEBOUNCE_SCANS)) begin
                        rel_cnt <= '0;
                        state   <= HELD;
                     end
                  end else begin
                     state <= SCAN;
                  end
               end
               HELD: begin
                  // Release must be seen on consecutive samples; any low
                  // sample restarts the count. No auto-repeat.
                  if (!any_low) begin
                     rel_cnt <= rel_nxt;
                     if (rel_nxt == DB_W'(DEBOUNCE_SCANS))
                        state <= SCAN;
                  end else begin
                     rel_cnt <= '0;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_valid   <= 1'b0;
         key_code    <= 4'h0;
         value       <= 32'h0;
         digit_count <= 4'h0;
      end else begin
         key_valid <= accept;
         if (accept)
            key_code <= accept_code;
         // clear beats a same-cycle accept; key_valid still pulses.
         if (clear) begin
            value       <= 32'h0;
            digit_count <= 4'h0;
         end else if (accept) begin
`ifdef KEYPAD_EDIT_EN
            if (accept_code == KEY_CLR) begin
               value       <= 32'h0;
               digit_count <= 4'h0;
            end else if (accept_code == KEY_BS) begin
               value <= value >> 4;
               if (digit_count != 4'h0)
                  digit_count <= digit_count - 4'h1;
            end else begin
               value <= {value[27:0], accept_code};
               if (digit_count < 4'(NUM_DIGITS))
                  digit_count <= digit_count + 4'h1;
            end
`else
            value <= {value[27:0], accept_code};
            if (digit_count < 4'(NUM_DIGITS))
               digit_count <= digit_count + 4'h1;
`endif
         end
      end
   end

endmodule
